// File: rtl/mano_alu_stage.sv
// rtl/mano_alu_stage.sv - adder/logic stage feeding the 16-bit accumulator register
//
// Purpose:
//   Latches an op and its operands on a Req/Ready handshake and computes the next AC value.
//   Updates the E (carry/extend) flip-flop.
//   Drives the result and a one-cycle Load strobe into the AC register.
//   Sequence: IDLE -> EXEC -> WB -> IDLE, so one op completes every three cycles.
//
// Ports:
//   i_clk    rising-edge clock
//   i_clr    asynchronous active-high reset
//   i_req    op request, accepted only while o_ready=1
//   i_op     op code: 0 NOP, 1 AND, 2 ADD, 3 LDA, 4 CMA, 5 CIR, 6 CIL, 7 INP,
//            8 CLE, 9 CME; codes 10-15 behave as NOP
//   i_ac     current AC value (AC register Q)
//   i_dr     data register operand
//   i_inpr   input register
//   o_ready  stage idle, able to accept a request
//   o_data   result to the AC register Data input
//   o_load   one-cycle write strobe to the AC register Load input (WB only)
//   o_e      E flip-flop
//   o_v      two's-complement overflow of the last ADD (present only with ALU_OVF_EN)
//
// Configuration macro:
//   ALU_OVF_EN  adds o_v and the ADD overflow logic; omitted when undefined.

module mano_alu_stage #(
  parameter int WIDTH     = 16,
  parameter int INP_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_clr,
  input  logic                 i_req,
  input  logic [3:0]           i_op,
  input  logic [WIDTH-1:0]     i_ac,
  input  logic [WIDTH-1:0]     i_dr,
  input  logic [INP_WIDTH-1:0] i_inpr,
  output logic                 o_ready,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_load,
  output logic                 o_e
`ifdef ALU_OVF_EN
  ,
  output logic                 o_v
`endif
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_LDA = 4'd3;
  localparam logic [3:0] OP_CMA = 4'd4;
  localparam logic [3:0] OP_CIR = 4'd5;
  localparam logic [3:0] OP_CIL = 4'd6;
  localparam logic [3:0] OP_INP = 4'd7;
  localparam logic [3:0] OP_CLE = 4'd8;
  localparam logic [3:0] OP_CME = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Latched operands, captured on the accepting edge so the AC/DR inputs may
  // change freely while the op is in flight.
  logic [3:0]           r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_d;
  logic [INP_WIDTH-1:0] r_inpr;

  logic [WIDTH-1:0]     r_data;
  logic                 r_e;
  logic                 r_load;

  logic                 w_accept;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_result;
  logic                 w_e_next;
  logic                 w_writes;

  assign w_accept = (r_state == S_IDLE) && i_req;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_req) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_op   <= OP_NOP;
      r_a    <= '0;
      r_d    <= '0;
      r_inpr <= '0;
    end else if (w_accept) begin
      r_op   <= i_op;
      r_a    <= i_ac;
      r_d    <= i_dr;
      r_inpr <= i_inpr;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Add at WIDTH+1 bits so the carry-out lands directly in the top bit.
  assign w_sum = {1'b0, r_a} + {1'b0, r_d};

  always_comb begin
    w_result = r_data;
    w_e_next = r_e;
    w_writes = 1'b0;
    case (r_op)
      OP_AND: begin
        w_result = r_a & r_d;
        w_writes = 1'b1;
      end
      OP_ADD: begin
        w_result = w_sum[WIDTH-1:0];
        w_e_next = w_sum[WIDTH];
        w_writes = 1'b1;
      end
      OP_LDA: begin
        w_result = r_d;
        w_writes = 1'b1;
      end
      OP_CMA: begin
        w_result = ~r_a;
        w_writes = 1'b1;
      end
      // Rotates run through E, so AC and E form a WIDTH+1 bit ring.
      OP_CIR: begin
        w_result = {r_e, r_a[WIDTH-1:1]};
        w_e_next = r_a[0];
        w_writes = 1'b1;
      end
      OP_CIL: begin
        w_result = {r_a[WIDTH-2:0], r_e};
        w_e_next = r_a[WIDTH-1];
        w_writes = 1'b1;
      end
      OP_INP: begin
        w_result = {r_a[WIDTH-1:INP_WIDTH], r_inpr};
        w_writes = 1'b1;
      end
      OP_CLE:  w_e_next = 1'b0;
      OP_CME:  w_e_next = ~r_e;
      default: begin
        w_result = r_data;
        w_e_next = r_e;
        w_writes = 1'b0;
      end
    endcase
  end

  // Results commit on the EXEC edge. Load is set on that same edge, so it is
  // high exactly for the WB cycle and is cleared again on the WB edge.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_data <= '0;
      r_e    <= 1'b0;
      r_load <= 1'b0;
    end else if (r_state == S_EXEC) begin
      if (w_writes) begin
        r_data <= w_result;
      end
      r_e    <= w_e_next;
      r_load <= w_writes;
    end else begin
      r_load <= 1'b0;
    end
  end

`ifdef ALU_OVF_EN
  logic r_v;
  logic w_v_next;

  // Signed overflow: both operands share a sign and the sum's sign differs.
  assign w_v_next = (r_a[WIDTH-1] == r_d[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_v <= 1'b0;
    end else if ((r_state == S_EXEC) && (r_op == OP_ADD)) begin
      r_v <= w_v_next;
    end
  end

  assign o_v = r_v;
`endif

  assign o_ready = (r_state == S_IDLE);
  assign o_data  = r_data;
  assign o_load  = r_load;
  assign o_e     = r_e;

endmodule

// File: tb/tb_mano_alu_stage.sv
// tb/tb_mano_alu_stage.sv - self-checking bench for mano_alu_stage

module tb_mano_alu_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic        req;
  logic [3:0]  op;
  logic [15:0] ac_in;
  logic [15:0] dr_in;
  logic [7:0]  inpr_in;
  logic        ready;
  logic [15:0] data;
  logic        load;
  logic        e;
`ifdef ALU_OVF_EN
  logic        v;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: what the AC-side outputs should hold.
  logic [15:0] m_data = 16'h0000;
  logic        m_e    = 1'b0;
  logic        m_v    = 1'b0;

  mano_alu_stage #(.WIDTH(16), .INP_WIDTH(8)) dut (
    .i_clk   (clk),
    .i_clr   (clr),
    .i_req   (req),
    .i_op    (op),
    .i_ac    (ac_in),
    .i_dr    (dr_in),
    .i_inpr  (inpr_in),
    .o_ready (ready),
    .o_data  (data),
    .o_load  (load),
    .o_e     (e)
`ifdef ALU_OVF_EN
    ,
    .o_v     (v)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model of one op, written from the instruction definitions
  // with ordinary integer arithmetic.
  task automatic model_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] d,
                          input logic [7:0] p, output logic wr);
    int unsigned s;
    int          ss;
    logic [15:0] nd;
    wr = 1'b0;
    case (o)
      4'd1: begin m_data = a & d; wr = 1'b1; end
      4'd2: begin
        s      = 32'(a) + 32'(d);
        m_data = 16'(s % 65536);
        m_e    = (s >= 65536);
        ss     = int'($signed(a)) + int'($signed(d));
        m_v    = (ss > 32767) || (ss < -32768);
        wr     = 1'b1;
      end
      4'd3: begin m_data = d; wr = 1'b1; end
      4'd4: begin m_data = 16'hFFFF - a; wr = 1'b1; end
      4'd5: begin
        nd     = (a / 16'd2) + (m_e ? 16'h8000 : 16'h0000);
        m_e    = (a % 16'd2) == 16'd1;
        m_data = nd;
        wr     = 1'b1;
      end
      4'd6: begin
        nd     = 16'((32'(a) * 2) % 65536) + (m_e ? 16'h0001 : 16'h0000);
        m_e    = (a >= 16'h8000);
        m_data = nd;
        wr     = 1'b1;
      end
      4'd7: begin m_data = (a / 16'd256) * 16'd256 + 16'(p); wr = 1'b1; end
      4'd8: m_e = 1'b0;
      4'd9: m_e = ~m_e;
      default: wr = 1'b0;
    endcase
  endtask

  // Issue one op from IDLE and follow it through EXEC and WB.
  // Sampled edge s: EXEC after s, WB (Load) after s+1, IDLE after s+2.
  task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] d,
                        input logic [7:0] p);
    logic [15:0] old_data;
    logic        wr;
    @(negedge clk);
    chk("pre_ready", 32'(ready), 32'd1);
    op = o; ac_in = a; dr_in = d; inpr_in = p; req = 1'b1;
    old_data = m_data;
    @(posedge clk); #1;
    req = 1'b0;
    ac_in = $urandom; dr_in = $urandom; inpr_in = 8'($urandom);
    chk("exec_ready", 32'(ready), 32'd0);
    chk("exec_load", 32'(load), 32'd0);
    chk("exec_data_hold", 32'(data), 32'(old_data));
    model_op(o, a, d, p, wr);
    @(posedge clk); #1;
    chk("wb_data", 32'(data), 32'(m_data));
    chk("wb_e", 32'(e), 32'(m_e));
    chk("wb_load", 32'(load), 32'(wr));
    chk("wb_ready", 32'(ready), 32'd0);
`ifdef ALU_OVF_EN
    chk("wb_v", 32'(v), 32'(m_v));
`endif
    @(posedge clk); #1;
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_load", 32'(load), 32'd0);
    chk("idle_data_hold", 32'(data), 32'(m_data));
  endtask

  initial begin
    int loads;
    int readies;
    clr = 1'b1; req = 1'b0; op = 4'd0; ac_in = '0; dr_in = '0; inpr_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_e", 32'(e), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // ADD with carry-out
    run_op(4'd2, 16'h0001, 16'hFFFF, 8'h00);
    chk("t1_data", 32'(data), 32'h0000);
    chk("t1_e", 32'(e), 32'd1);

    // Rotates through E
    run_op(4'd5, 16'h8001, 16'h0000, 8'h00);
    chk("t2_cir", 32'(data), 32'hC000);
    chk("t2_cir_e", 32'(e), 32'd1);
    run_op(4'd6, 16'hC000, 16'h0000, 8'h00);
    chk("t2_cil", 32'(data), 32'h8001);
    chk("t2_cil_e", 32'(e), 32'd1);

    // INP then CME
    run_op(4'd7, 16'h1234, 16'h0000, 8'hAB);
    chk("t3_inp", 32'(data), 32'h12AB);
    run_op(4'd9, 16'h5555, 16'h0000, 8'h00);
    chk("t3_cme_e", 32'(e), 32'd0);
    chk("t3_cme_data", 32'(data), 32'h12AB);

    // Req held high: one accept per 3 cycles, no extra loads
    @(negedge clk);
    op = 4'd3; dr_in = 16'hBEEF; ac_in = 16'h0000; req = 1'b1;
    loads = 0; readies = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (load) loads++;
      if (ready) readies++;
    end
    req = 1'b0;
    chk("t4_loads", 32'(loads), 32'd4);
    chk("t4_readies", 32'(readies), 32'd4);
    chk("t4_data", 32'(data), 32'hBEEF);
    m_data = 16'hBEEF;

    // Reset during EXEC of ADD; set E first so the clear is visible
    run_op(4'd9, 16'h0000, 16'h0000, 8'h00);
    chk("t5_pre_e", 32'(e), 32'd1);
    @(negedge clk);
    op = 4'd2; ac_in = 16'h0001; dr_in = 16'hFFFF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    clr = 1'b1;
    #1;
    chk("t5_load", 32'(load), 32'd0);
    chk("t5_e", 32'(e), 32'd0);
    chk("t5_data", 32'(data), 32'd0);
    chk("t5_ready", 32'(ready), 32'd1);
    @(negedge clk);
    clr = 1'b0;
    m_data = 16'h0000; m_e = 1'b0; m_v = 1'b0;
    loads = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (load) loads++;
    end
    chk("t5_no_load", 32'(loads), 32'd0);
    chk("t5_ready_after", 32'(ready), 32'd1);

`ifdef ALU_OVF_EN
    run_op(4'd2, 16'h7FFF, 16'h0001, 8'h00);
    chk("t6_data", 32'(data), 32'h8000);
    chk("t6_v", 32'(v), 32'd1);
    chk("t6_e", 32'(e), 32'd0);
    run_op(4'd1, 16'h0F0F, 16'h00FF, 8'h00);
    chk("t6_v_hold", 32'(v), 32'd1);
`endif

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
